// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM state enum, opcodes, ALU codes and datapath mux encodings.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BEQ,
    ADDIEX,
    ADDIWB,
    JUMP,
    ERROR
  } mc_state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_JUMP       = 2'b10;

  // States that hold mem_req and therefore wait on mem_ready.
  function automatic logic is_mem_state(input mc_state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath/memory side. Counters are only live with MC_PERF_CNT_EN.
// Memory handshake: mem_req is held high (with IorD/MemWrite stable) until a
// cycle in which mem_ready=1; that cycle completes the access. A req dropped
// without ready (reset) is an abandoned access and must be ignored.
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             Branch;
  logic [1:0]       PCSrc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [5:0]       ALUControl;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite,
           illegal, instr_cnt, cycle_cnt
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite,
           illegal, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/mc_mem_timeout.sv
// Memory wait counter shared by the three request states; flags a timeout
// when a request would go unanswered for MEM_TIMEOUT cycles.
module mc_mem_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] wait_cnt;

  // Clearing on ready covers back-to-back request states (MEMWR -> FETCH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!active || mem_ready) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  // Ready in the final allowed cycle wins over the timeout.
  assign timeout = active && !mem_ready && (wait_cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller for the multicycle MIPS datapath over a unified memory.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mips_multicycle_ctrl_if.master bus,
  output mc_state_t             dbg_state
);

  mc_state_t state;
  mc_state_t next_state;
  logic      mem_active;
  logic      timeout;

  assign mem_active = is_mem_state(state);
  assign dbg_state  = state;

  mc_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_timeout (
    .clk       (CLK),
    .rst_n     (RESET),
    .active    (mem_active),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH:  if (bus.mem_ready) next_state = DECODE;
              else if (timeout)  next_state = ERROR;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXEC;
          OP_BEQ:       next_state = BEQ;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = ERROR;
        endcase
      end
      MEMADR: next_state = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) next_state = MEMWB;
              else if (timeout)  next_state = ERROR;
      MEMWB:  next_state = FETCH;
      MEMWR:  if (bus.mem_ready) next_state = FETCH;
              else if (timeout)  next_state = ERROR;
      EXEC:   next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BEQ:    next_state = FETCH;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: next_state = FETCH;
      JUMP:   next_state = FETCH;
      ERROR:  next_state = ERROR;
      default: next_state = ERROR;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.PCSrc      = PC_ALU_RESULT;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_REG;
    bus.ALUControl = 6'h00;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.ALUSrcB    = SRCB_FOUR;
        bus.ALUControl = ALU_ADD;
        // IR and PC+4 are only captured in the cycle the fetch completes.
        bus.IRWrite    = bus.mem_ready;
        bus.PCWrite    = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB    = SRCB_IMM_SH2;
        bus.ALUControl = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = ALU_ADD;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = bus.Funct;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_SUB;
        bus.Branch     = 1'b1;
        bus.PCSrc      = PC_ALU_OUT;
      end
      ADDIWB: bus.RegWrite = 1'b1;
      JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = PC_JUMP;
      end
      ERROR: bus.illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instr_q;
  logic [CNT_W-1:0] cycle_q;

  // An instruction retires on every return to FETCH; IDLE -> FETCH is not one.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else if (state != ERROR) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (next_state == FETCH && state != FETCH && state != IDLE)
        instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign bus.instr_cnt = instr_q;
  assign bus.cycle_cnt = cycle_q;
`else
  assign bus.instr_cnt = {CNT_W{1'b0}};
  assign bus.cycle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed + randomized bench for mips_multicycle_ctrl: instruction-level
// reference model (per-opcode step lists, memory waits, timeout) checked every cycle.
module tb_mips_multicycle_ctrl;
  import mips_mc_pkg::*;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic      CLK;
  logic      RESET;
  mc_state_t dbg_state;
  int        compared;
  int        mismatched;
  int        cyc_m;
  int        instr_m;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [20:0] obs_ctrl();
    return {bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch,
            bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.illegal};
  endfunction

  // Control word each named step must present, straight from the step descriptions.
  function automatic logic [20:0] exp_ctrl(input mc_state_t st, input logic rdy, input logic [5:0] fn);
    logic req, iord, mw, irw, pcw, br, sa, rd, m2r, rw, ill;
    logic [1:0] pcs, sb;
    logic [5:0] alu;
    {req, iord, mw, irw, pcw, br, sa, rd, m2r, rw, ill} = '0;
    pcs = 2'b00; sb = 2'b00; alu = 6'h00;
    case (st)
      FETCH:  begin req = 1; sb = 2'b01; alu = 6'h20; irw = rdy; pcw = rdy; end
      DECODE: begin sb = 2'b11; alu = 6'h20; end
      MEMADR: begin sa = 1; sb = 2'b10; alu = 6'h20; end
      MEMRD:  begin req = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin req = 1; iord = 1; mw = 1; end
      EXEC:   begin sa = 1; alu = fn; end
      ALUWB:  begin rw = 1; rd = 1; end
      BEQ:    begin sa = 1; alu = 6'h22; br = 1; pcs = 2'b01; end
      ADDIEX: begin sa = 1; sb = 2'b10; alu = 6'h20; end
      ADDIWB: rw = 1;
      JUMP:   begin pcw = 1; pcs = 2'b10; end
      ERROR:  ill = 1;
      default: ;
    endcase
    return {req, iord, mw, irw, pcw, br, pcs, sa, sb, alu, rd, m2r, rw, ill};
  endfunction

  task automatic check_counters(input string tag);
`ifdef MC_PERF_CNT_EN
    check({tag, "_instr_cnt"}, bus.instr_cnt, instr_m);
    check({tag, "_cycle_cnt"}, bus.cycle_cnt, cyc_m);
`else
    check({tag, "_instr_cnt"}, bus.instr_cnt, 32'd0);
    check({tag, "_cycle_cnt"}, bus.cycle_cnt, 32'd0);
`endif
  endtask

  // One clock: drive ready, check at negedge, advance to posedge+1.
  task automatic step(input string tag, input mc_state_t st, input logic rdy);
    bus.mem_ready = rdy;
    @(negedge CLK);
    check({tag, "_state"}, 32'(dbg_state), 32'(st));
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(st, rdy, bus.Funct)));
    check_counters(tag);
    @(posedge CLK);
    #1;
    if (st != ERROR) cyc_m++;
  endtask

  task automatic do_reset();
    #2;
    RESET = 1'b0;
    #1;
    check("rst_async_req", 32'(bus.mem_req), 32'd0);
    check("rst_async_state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    check("rst_ctrl", 32'(obs_ctrl()), 32'd0);
    cyc_m = 0;
    instr_m = 0;
    check_counters("rst");
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    step("idle", IDLE, 1'($urandom_range(0, 1)));
  endtask

  // Runs one instruction from FETCH; wf/wd are wait cycles for the fetch and data
  // accesses. A wait of MEM_TIMEOUT or more must end in ERROR.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int wf, input int wd);
    mc_state_t seq[$];
    int w;
    bus.Op = op;
    bus.Funct = fn;
    bus.Zero = zero;
    case (op)
      6'h23:   seq = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      6'h2B:   seq = '{FETCH, DECODE, MEMADR, MEMWR};
      6'h00:   seq = '{FETCH, DECODE, EXEC, ALUWB};
      6'h04:   seq = '{FETCH, DECODE, BEQ};
      6'h08:   seq = '{FETCH, DECODE, ADDIEX, ADDIWB};
      6'h02:   seq = '{FETCH, DECODE, JUMP};
      default: seq = '{FETCH, DECODE, ERROR};
    endcase
    foreach (seq[i]) begin
      if (seq[i] == ERROR) begin
        step(tag, ERROR, 1'($urandom_range(0, 1)));
        return;
      end else if (seq[i] == FETCH || seq[i] == MEMRD || seq[i] == MEMWR) begin
        w = (seq[i] == FETCH) ? wf : wd;
        for (int c = 0; c <= MEM_TIMEOUT; c++) begin
          if (c == MEM_TIMEOUT) begin
            step({tag, "_timeout"}, ERROR, 1'b0);
            return;
          end
          if (c == w) begin
            step(tag, seq[i], 1'b1);
            break;
          end
          step({tag, "_wait"}, seq[i], 1'b0);
        end
      end else begin
        step(tag, seq[i], 1'($urandom_range(0, 1)));
      end
    end
    instr_m++;
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int wf;
    int wd;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    compared = 0;
    mismatched = 0;
    cyc_m = 0;
    instr_m = 0;
    RESET = 1'b1;
    bus.Op = 6'h00;
    bus.Funct = 6'h00;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();

    run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);
    run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0);
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 0, 0);
`ifdef MC_PERF_CNT_EN
    check("perf_instr_at_4th_fetch", bus.instr_cnt, 32'd3);
    check("perf_cycle_at_4th_fetch", bus.cycle_cnt, 32'd12);
`else
    check("perf_instr_tied", bus.instr_cnt, 32'd0);
    check("perf_cycle_tied", bus.cycle_cnt, 32'd0);
`endif

    do_reset();
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
    run_instr("beq_z1", 6'h04, 6'h2A, 1'b1, 0, 0);
    run_instr("beq_z0", 6'h04, 6'h25, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      wf = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 3);
      wd = $urandom_range(0, 4);
      run_instr("rand", op, 6'($urandom), 1'($urandom), wf, wd);
    end

    run_instr("illegal_op", 6'h3F, 6'h00, 1'b0, 0, 0);
    for (int n = 0; n < 19; n++) step("illegal_hold", ERROR, 1'($urandom_range(0, 1)));
    do_reset();

    run_instr("fetch_timeout", 6'h00, 6'h20, 1'b0, MEM_TIMEOUT, 0);
    for (int n = 0; n < 3; n++) step("timeout_hold", ERROR, 1'b1);
    do_reset();
    run_instr("fetch_last_cycle", 6'h00, 6'h24, 1'b0, MEM_TIMEOUT - 1, 0);
    run_instr("lw_last_cycle", 6'h23, 6'h00, 1'b0, 0, MEM_TIMEOUT - 1);
    run_instr("sw_timeout", 6'h2B, 6'h00, 1'b0, 1, MEM_TIMEOUT + 2);
    step("sw_timeout_hold", ERROR, 1'b1);
    do_reset();
    run_instr("lw_timeout", 6'h23, 6'h00, 1'b0, 2, MEM_TIMEOUT);
    step("lw_timeout_hold", ERROR, 1'b0);
    do_reset();
    run_instr("final_add", 6'h00, 6'h20, 1'b1, 1, 0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
